mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares the single-ported RAM between the processor's instruction-fetch and data-access requesters. Registered two-state grant FSM gives data accesses priority, with a bounded-starvation guard for fetch. Drives the RAM request lines and returns per-requester wait/load. Sits between the datapath's request unit and the RAM model.

## Interface
- `MAX_DSTREAK`, default 4: maximum consecutive data grants while a fetch is pending; the next grant then goes to fetch. Legal range 1..15.
- `CLK` in 1: system clock, rising edge.
- `nRST` in 1: asynchronous, active-low reset.
- `iREN` in 1: fetch request.
- `iaddr` in 32: fetch address (`word_t`).
- `iwait` out 1: fetch not yet complete.
- `iload` out 32: fetched word.
- `dREN` in 1: data read request.
- `dWEN` in 1: data write request.
- `daddr` in 32: data address.
- `dstore` in 32: write data.
- `dwait` out 1: data access not yet complete.
- `dload` out 32: read data.
- `ramREN` out 1: RAM read enable.
- `ramWEN` out 1: RAM write enable.
- `ramaddr` out 32: RAM address.
- `ramstore` out 32: RAM write data.
- `ramload` in 32: RAM read data.
- `ramstate` in 2: `ramstate_t` = FREE, BUSY, ACCESS, ERROR.

## Operation
- Clocking and reset: one clock (`CLK`); reset is asynchronous and active-low (`nRST`).
- States: `IDLE`, `IGNT`, `DGNT`, held in a registered `arb_state_t`. Registered `dstreak` counter, width `$clog2(MAX_DSTREAK+1)`.
- `IDLE`: RAM enables are 0. Next state is chosen from the current requests (`dreq = dREN|dWEN`):
  - `dreq` and (!`iREN` or `dstreak` < `MAX_DSTREAK`) → `DGNT`.
  - Otherwise, `iREN` → `IGNT`.
  - Otherwise, stay in `IDLE`.
- `IGNT`:
  - Outputs: `ramREN`=1, `ramaddr`=`iaddr`.
  - On `ramstate`==ACCESS: `iwait`=0 that cycle, `iload`=`ramload`; go to `IDLE`.
- `DGNT`:
  - Outputs: `ramaddr`=`daddr`, `ramstore`=`dstore`.
  - If `dWEN`, then `ramWEN`=1 and `ramREN`=0; otherwise `ramREN`=1. Write wins when both are set.
  - On ACCESS: `dwait`=0, `dload`=`ramload`; go to `IDLE`.
- FREE/BUSY in a grant state: hold the state; the wait output stays 1.
- ERROR: no completion; wait stays 1; return to `IDLE` and re-arbitrate. This retries the access with the same priority rules.
- Withdrawal: if the granted requester drops its enable(s) before ACCESS, RAM enables go to 0 that same cycle and the FSM returns to `IDLE`. No completion is signalled.
- `dstreak` updates on each transition out of `IDLE`:
  - Into `DGNT` with `iREN`=1: saturating increment.
  - Into `IGNT`, or any transition with `iREN`=0: clear to 0.
- Wait outputs are combinational: `iwait` = `iREN` & !(IGNT & ACCESS); `dwait` = `dreq` & !(DGNT & ACCESS). A non-requesting side never sees wait=1.
- `iload`/`dload` are driven with `ramload` continuously. They are valid only in the completion cycle.
- When not granted, `ramaddr`/`ramstore` = 0.

## Timing
- Reset: state=`IDLE`, `dstreak`=0, `ramREN`=`ramWEN`=0, `ramaddr`=`ramstore`=0. `iwait`/`dwait` equal their request inputs (no completion is possible in `IDLE`).
- Arbitration costs one cycle. Minimum latency from request assertion to wait low is 2 cycles (arbitrate, then ACCESS).
- Requesters hold address, data and enables stable while wait=1.
- After each completion the FSM spends one cycle in `IDLE`; back-to-back accesses therefore run at most one per 2 cycles.
- Simultaneous requests in `IDLE`: data wins unless `dstreak`==`MAX_DSTREAK` with a fetch pending.
- Reset asserted mid-grant: RAM enables drop immediately (asynchronously) and the in-flight access is abandoned. After release the FSM re-arbitrates from `IDLE`.

## Structure
- `cpu_types_pkg` gains `arb_state_t` (`IDLE`, `IGNT`, `DGNT`). It already provides `word_t` and `ramstate_t`.
- The arbiter is one module with no sub-modules. Grant selection and the streak counter are small enough to stay inline.
- Wrap the requester side in `mem_arbiter_if` (modports `arb`, `req`, `tb`) to match the control-unit interface style.

## Test plan
- Lone fetch: `iREN`=1, `iaddr`=0x40; RAM returns ACCESS on the 2nd grant cycle with `ramload`=0x2000_0001. Required: `ramREN`=1, `ramaddr`=0x40; `iwait` low only in that cycle; `iload`=0x2000_0001.
- Collision: `iREN`=`dREN`=1 in `IDLE`, `daddr`=0x80. Required: `DGNT` first; `ramaddr`=0x80; fetch is granted after the data ACCESS plus one `IDLE` cycle.
- Starvation guard with `MAX_DSTREAK`=4: `iREN` held, `dREN` reissued after each completion. Required: exactly 4 data grants, then one `IGNT`; `dstreak` back to 0.
- Write precedence: `dREN`=`dWEN`=1, `dstore`=0xDEAD_BEEF. Required: `ramWEN`=1, `ramREN`=0, `ramstore`=0xDEAD_BEEF.
- ERROR then withdrawal: ERROR during `DGNT` → `dwait` stays 1, back to `IDLE`, re-granted. Then `dREN` dropped mid-grant → RAM enables 0 that cycle, no completion pulse.
- Reset mid-access: `nRST` pulled low during `IGNT` with BUSY. Required: `ramREN`=0 immediately, state `IDLE`; after release, a fresh arbitration cycle precedes any grant.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU memory-side types: word, RAM handshake state and arbiter grant state.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IGNT = 2'd1,
        DGNT = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side bundle between the datapath request unit and the RAM arbiter.
interface mem_arbiter_if;
    import cpu_types_pkg::*;

    logic  iREN;
    word_t iaddr;
    logic  iwait;
    word_t iload;

    logic  dREN;
    logic  dWEN;
    word_t daddr;
    word_t dstore;
    logic  dwait;
    word_t dload;

    modport arb (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore,
        output iwait, iload, dwait, dload
    );

    modport req (
        output iREN, iaddr, dREN, dWEN, daddr, dstore,
        input  iwait, iload, dwait, dload
    );

    modport tb (
        output iREN, iaddr, dREN, dWEN, daddr, dstore,
        input  iwait, iload, dwait, dload
    );

endinterface

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: data accesses win, but a pending fetch is granted
// after MAX_DSTREAK consecutive data grants.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned MAX_DSTREAK = 4
) (
    input  logic          CLK,
    input  logic          nRST,
    mem_arbiter_if.arb    bus,
    output logic          ramREN,
    output logic          ramWEN,
    output word_t         ramaddr,
    output word_t         ramstore,
    input  word_t         ramload,
    input  ramstate_t     ramstate
);

    localparam int unsigned SW = $clog2(MAX_DSTREAK + 1);
    localparam logic [SW-1:0] MAX_S = SW'(MAX_DSTREAK);

    arb_state_t    state_q;
    logic [SW-1:0] dstreak_q;
    logic [SW-1:0] dstreak_d;
    logic          dreq;
    logic          fetch_due;
    logic          ram_done;

    assign dreq      = bus.dREN | bus.dWEN;
    assign fetch_due = bus.iREN && (dstreak_q >= MAX_S);
    assign ram_done  = (ramstate == ACCESS) || (ramstate == ERROR);

    // Streak only grows while a fetch is actually waiting behind the data side.
    always_comb begin
        dstreak_d = '0;
        if (bus.iREN)
            dstreak_d = (dstreak_q == MAX_S) ? MAX_S : dstreak_q + 1'b1;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= IDLE;
            dstreak_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (dreq && !fetch_due) begin
                        state_q   <= DGNT;
                        dstreak_q <= dstreak_d;
                    end else if (bus.iREN) begin
                        state_q   <= IGNT;
                        dstreak_q <= '0;
                    end
                end
                // ERROR leaves the grant without completing so the access is re-arbitrated.
                IGNT: if (!bus.iREN || ram_done) state_q <= IDLE;
                DGNT: if (!dreq || ram_done)     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        unique case (state_q)
            IGNT: begin
                ramREN  = bus.iREN;
                ramaddr = bus.iaddr;
            end
            DGNT: begin
                ramWEN   = bus.dWEN;
                ramREN   = bus.dREN & ~bus.dWEN;
                ramaddr  = bus.daddr;
                ramstore = bus.dstore;
            end
            default: ;
        endcase
    end

    assign bus.iwait = bus.iREN & ~((state_q == IGNT) && (ramstate == ACCESS));
    assign bus.dwait = dreq     & ~((state_q == DGNT) && (ramstate == ACCESS));
    assign bus.iload = ramload;
    assign bus.dload = ramload;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with an ownership-level reference model.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int MAX = 4;
  localparam int NONE = 0, FET = 1, DAT = 2;

  logic      CLK = 1'b0;
  logic      nRST;
  logic      ramREN, ramWEN;
  word_t     ramaddr, ramstore, ramload;
  ramstate_t ramstate;

  mem_arbiter_if b ();

  mem_arbiter #(.MAX_DSTREAK(MAX)) dut (
    .CLK(CLK), .nRST(nRST), .bus(b.arb),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who owns the RAM, and how many data grants a waiting fetch has sat through.
  int m_own, m_streak;

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      m_own    <= NONE;
      m_streak <= 0;
    end else if (m_own == NONE) begin
      if ((b.dREN || b.dWEN) && !(b.iREN && m_streak >= MAX)) begin
        m_own    <= DAT;
        m_streak <= b.iREN ? m_streak + 1 : 0;
      end else if (b.iREN) begin
        m_own    <= FET;
        m_streak <= 0;
      end
    end else begin
      if (!(m_own == FET ? b.iREN : (b.dREN || b.dWEN)) || ramstate == ACCESS || ramstate == ERROR)
        m_own <= NONE;
    end
  end

  always @(negedge CLK) begin
    if (nRST) begin
      logic dreq, live, done;
      logic e_ren, e_wen;
      logic [31:0] e_addr, e_store;
      dreq = b.dREN | b.dWEN;
      live = (m_own == FET) ? b.iREN : (m_own == DAT) ? dreq : 1'b0;
      done = live && ramstate == ACCESS;
      e_ren = live && (m_own == FET || !b.dWEN);
      e_wen = live && m_own == DAT && b.dWEN;
      e_addr = (m_own == FET) ? b.iaddr : (m_own == DAT) ? b.daddr : 32'h0;
      e_store = (m_own == DAT) ? b.dstore : 32'h0;
      chk("m_ramREN", ramREN, e_ren);
      chk("m_ramWEN", ramWEN, e_wen);
      chk("m_ramaddr", ramaddr, e_addr);
      chk("m_ramstore", ramstore, e_store);
      chk("m_iwait", b.iwait, b.iREN && !(done && m_own == FET));
      chk("m_dwait", b.dwait, dreq && !(done && m_own == DAT));
      if (done && m_own == FET) chk("m_iload", b.iload, ramload);
      if (done && m_own == DAT) chk("m_dload", b.dload, ramload);
    end
  end

  task automatic next_cycle();
    @(posedge CLK); #1;
  endtask

  task automatic sample();
    @(negedge CLK);
  endtask

  task automatic idle_inputs();
    b.iREN = 0; b.dREN = 0; b.dWEN = 0;
    b.iaddr = 0; b.daddr = 0; b.dstore = 0;
    ramstate = FREE; ramload = 0;
  endtask

  string seq;

  initial begin
    nRST = 1'b0;
    idle_inputs();
    b.dREN = 1;
    sample();
    chk("rst_ramREN", ramREN, 0);
    chk("rst_ramWEN", ramWEN, 0);
    chk("rst_ramaddr", ramaddr, 0);
    chk("rst_dwait", b.dwait, 1);
    chk("rst_iwait", b.iwait, 0);
    next_cycle(); nRST = 1'b1; idle_inputs();
    sample();

    // Lone fetch, ACCESS on the second grant cycle
    next_cycle(); b.iREN = 1; b.iaddr = 32'h40;
    sample(); chk("lf_idle_ren", ramREN, 0); chk("lf_idle_iwait", b.iwait, 1);
    next_cycle(); ramstate = BUSY;
    sample(); chk("lf_ren", ramREN, 1); chk("lf_addr", ramaddr, 32'h40); chk("lf_busy_iwait", b.iwait, 1);
    next_cycle(); ramstate = ACCESS; ramload = 32'h2000_0001;
    sample(); chk("lf_iwait", b.iwait, 0); chk("lf_iload", b.iload, 32'h2000_0001);
    next_cycle(); idle_inputs();
    sample(); chk("lf_after_ren", ramREN, 0);

    // Collision: data first, fetch after one idle cycle
    next_cycle(); b.iREN = 1; b.iaddr = 32'h44; b.dREN = 1; b.daddr = 32'h80;
    sample();
    next_cycle(); ramstate = ACCESS; ramload = 32'h1234_5678;
    sample(); chk("col_daddr", ramaddr, 32'h80); chk("col_dwait", b.dwait, 0); chk("col_iwait", b.iwait, 1);
    next_cycle(); b.dREN = 0; ramstate = FREE;
    sample(); chk("col_idle_ren", ramREN, 0);
    next_cycle(); ramstate = ACCESS;
    sample(); chk("col_iaddr", ramaddr, 32'h44); chk("col_iwait_done", b.iwait, 0);
    next_cycle(); idle_inputs();
    sample();

    // Starvation guard: four data grants then one fetch, repeating
    next_cycle(); b.iREN = 1; b.iaddr = 32'h600; b.dREN = 1; b.daddr = 32'h500;
    ramstate = ACCESS; ramload = 32'h0BAD_F00D;
    seq = "";
    for (int k = 0; k < 20; k++) begin
      sample();
      if (ramREN && ramaddr == 32'h500) seq = {seq, "D"};
      else if (ramREN && ramaddr == 32'h600) seq = {seq, "I"};
      if (k < 19) next_cycle();
    end
    n_chk++;
    if (seq != "DDDDIDDDDI") begin
      n_fail++;
      $display("FAIL starve_seq: got %s want DDDDIDDDDI", seq);
    end
    next_cycle(); idle_inputs();
    sample();

    // Write wins over read
    next_cycle(); b.dREN = 1; b.dWEN = 1; b.daddr = 32'h100; b.dstore = 32'hDEAD_BEEF;
    sample(); chk("wr_idle_dwait", b.dwait, 1);
    next_cycle(); ramstate = BUSY;
    sample(); chk("wr_wen", ramWEN, 1); chk("wr_ren", ramREN, 0); chk("wr_store", ramstore, 32'hDEAD_BEEF);
    next_cycle(); ramstate = ACCESS;
    sample(); chk("wr_dwait", b.dwait, 0);
    next_cycle(); idle_inputs();
    sample();

    // ERROR retries, then withdrawal mid-grant
    next_cycle(); b.dREN = 1; b.daddr = 32'h200;
    sample();
    next_cycle(); ramstate = ERROR;
    sample(); chk("err_ren", ramREN, 1); chk("err_dwait", b.dwait, 1);
    next_cycle(); ramstate = FREE;
    sample(); chk("err_idle_ren", ramREN, 0); chk("err_idle_dwait", b.dwait, 1);
    next_cycle(); ramstate = BUSY;
    sample(); chk("err_regrant", ramREN, 1);
    next_cycle(); b.dREN = 0;
    sample(); chk("wd_ren", ramREN, 0); chk("wd_wen", ramWEN, 0); chk("wd_dwait", b.dwait, 0);
    next_cycle(); ramstate = ACCESS;
    sample(); chk("wd_nodone_ren", ramREN, 0); chk("wd_nodone_dwait", b.dwait, 0);
    next_cycle(); idle_inputs();
    sample();

    // Reset during a busy fetch grant
    next_cycle(); b.iREN = 1; b.iaddr = 32'h300;
    sample();
    next_cycle(); ramstate = BUSY;
    sample(); chk("rm_ren_pre", ramREN, 1);
    #2 nRST = 1'b0;
    #1 chk("rm_ren_async", ramREN, 0); chk("rm_addr_async", ramaddr, 0); chk("rm_iwait", b.iwait, 1);
    next_cycle();
    sample(); chk("rm_ren_held", ramREN, 0);
    #2 nRST = 1'b1;
    #1 chk("rm_ren_arb", ramREN, 0);
    next_cycle(); ramstate = ACCESS; ramload = 32'h0000_0300;
    sample(); chk("rm_regrant", ramREN, 1); chk("rm_iwait_done", b.iwait, 0);
    next_cycle(); idle_inputs();
    sample();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
